// File: rtl/aes_pkg.sv
// Shared constants and state encoding for the AES round-key sequencer slice.
package aes_pkg;

  localparam int unsigned NR    = 10;
  localparam int unsigned KEY_W = 128;
  localparam int unsigned RND_W = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    ISSUE = 2'd2
  } state_e;

endpackage

// File: rtl/aes_rk_mux.sv
// Combinational 11:1 select of one 128-bit round key by round index.
module aes_rk_mux
  import aes_pkg::*;
(
  input  logic [RND_W-1:0] sel,
  input  logic [KEY_W-1:0] key_0,
  input  logic [KEY_W-1:0] key_1,
  input  logic [KEY_W-1:0] key_2,
  input  logic [KEY_W-1:0] key_3,
  input  logic [KEY_W-1:0] key_4,
  input  logic [KEY_W-1:0] key_5,
  input  logic [KEY_W-1:0] key_6,
  input  logic [KEY_W-1:0] key_7,
  input  logic [KEY_W-1:0] key_8,
  input  logic [KEY_W-1:0] key_9,
  input  logic [KEY_W-1:0] key_10,
  output logic [KEY_W-1:0] key_out
);

  always_comb begin
    key_out = '0;
    case (sel)
      4'd0:    key_out = key_0;
      4'd1:    key_out = key_1;
      4'd2:    key_out = key_2;
      4'd3:    key_out = key_3;
      4'd4:    key_out = key_4;
      4'd5:    key_out = key_5;
      4'd6:    key_out = key_6;
      4'd7:    key_out = key_7;
      4'd8:    key_out = key_8;
      4'd9:    key_out = key_9;
      4'd10:   key_out = key_10;
      default: key_out = '0;
    endcase
  end

endmodule

// File: rtl/aes_round_key_sequencer.sv
// Waits out KeyGen's serial load, then hands round keys 0..NR to the cipher
// datapath one per valid/ready handshake.
module aes_round_key_sequencer #(
  parameter int unsigned KEY_BITS = 128,
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned NR       = aes_pkg::NR
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_reload,
  input  logic [127:0] Key_0,
  input  logic [127:0] Key_1,
  input  logic [127:0] Key_2,
  input  logic [127:0] Key_3,
  input  logic [127:0] Key_4,
  input  logic [127:0] Key_5,
  input  logic [127:0] Key_6,
  input  logic [127:0] Key_7,
  input  logic [127:0] Key_8,
  input  logic [127:0] Key_9,
  input  logic [127:0] Key_10,
  input  logic         start,
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         keys_ready,
  output logic         busy,
  output logic         done
);
  import aes_pkg::*;

  localparam int unsigned      CNT_W    = $clog2(KEY_BITS + SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_BITS + SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(KEY_BITS + SETTLE);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NR);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   load_cnt_q, load_cnt_d;
  logic               rk_valid_q, rk_valid_d;
  logic [KEY_W-1:0]   rk_data_q, rk_data_d;
  logic [RND_W-1:0]   rk_round_q, rk_round_d;
  logic               rk_last_q, rk_last_d;
  logic               keys_ready_q, keys_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [RND_W-1:0]   mux_sel;
  logic [KEY_W-1:0]   mux_key;

  aes_rk_mux u_rk_mux (
    .sel    (mux_sel),
    .key_0  (Key_0),
    .key_1  (Key_1),
    .key_2  (Key_2),
    .key_3  (Key_3),
    .key_4  (Key_4),
    .key_5  (Key_5),
    .key_6  (Key_6),
    .key_7  (Key_7),
    .key_8  (Key_8),
    .key_9  (Key_9),
    .key_10 (Key_10),
    .key_out(mux_key)
  );

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    rk_valid_d   = rk_valid_q;
    rk_data_d    = rk_data_q;
    rk_round_d   = rk_round_q;
    rk_last_d    = rk_last_q;
    keys_ready_d = keys_ready_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    mux_sel      = rk_round_q;

    if (key_reload) begin
      state_d      = LOAD;
      load_cnt_d   = '0;
      keys_ready_d = 1'b0;
      rk_valid_d   = 1'b0;
      busy_d       = 1'b0;
      rk_round_d   = '0;
      rk_last_d    = 1'b0;
    end else begin
      // Count keeps running (saturating) after LOAD so it never wraps back into range.
      if (load_cnt_q != CNT_MAX) load_cnt_d = load_cnt_q + CNT_W'(1);
      case (state_q)
        LOAD: begin
          if (load_cnt_q == CNT_LAST) begin
            state_d      = IDLE;
            keys_ready_d = 1'b1;
          end
        end
        IDLE: begin
          if (start) begin
            state_d    = ISSUE;
            rk_valid_d = 1'b1;
            busy_d     = 1'b1;
            rk_round_d = '0;
            mux_sel    = '0;
            rk_data_d  = mux_key;
            rk_last_d  = (RND_LAST == '0);
          end
        end
        ISSUE: begin
          if (rk_ready) begin
            if (rk_round_q == RND_LAST) begin
              state_d    = IDLE;
              rk_valid_d = 1'b0;
              busy_d     = 1'b0;
              rk_round_d = '0;
              rk_last_d  = 1'b0;
              done_d     = 1'b1;
            end else begin
              rk_round_d = rk_round_q + RND_W'(1);
              mux_sel    = rk_round_d;
              rk_data_d  = mux_key;
              rk_last_d  = (rk_round_d == RND_LAST);
            end
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= LOAD;
      load_cnt_q   <= '0;
      rk_valid_q   <= 1'b0;
      rk_data_q    <= '0;
      rk_round_q   <= '0;
      rk_last_q    <= 1'b0;
      keys_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      rk_valid_q   <= rk_valid_d;
      rk_data_q    <= rk_data_d;
      rk_round_q   <= rk_round_d;
      rk_last_q    <= rk_last_d;
      keys_ready_q <= keys_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rk_valid   = rk_valid_q;
  assign rk_data    = rk_data_q;
  assign rk_round   = rk_round_q;
  assign rk_last    = rk_last_q;
  assign keys_ready = keys_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Directed bench for aes_round_key_sequencer with a cycle-level reference model.
module tb_aes_round_key_sequencer;

  localparam int LOAD_EDGES = 130;
  localparam int NRND       = 10;

  localparam logic [127:0] K0_LIT  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_LIT  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K3_LIT  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] K10_LIT = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         key_reload = 1'b0;
  logic         start = 1'b0;
  logic         rk_ready = 1'b0;
  logic [127:0] key_in [0:10];
  logic         rk_valid;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_last;
  logic         keys_ready;
  logic         busy;
  logic         done;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  aes_round_key_sequencer #(.KEY_BITS(128), .SETTLE(2), .NR(10)) dut (
    .clk(clk), .reset_n(reset_n), .key_reload(key_reload),
    .Key_0(key_in[0]), .Key_1(key_in[1]), .Key_2(key_in[2]), .Key_3(key_in[3]),
    .Key_4(key_in[4]), .Key_5(key_in[5]), .Key_6(key_in[6]), .Key_7(key_in[7]),
    .Key_8(key_in[8]), .Key_9(key_in[9]), .Key_10(key_in[10]),
    .start(start), .rk_ready(rk_ready),
    .rk_valid(rk_valid), .rk_data(rk_data), .rk_round(rk_round), .rk_last(rk_last),
    .keys_ready(keys_ready), .busy(busy), .done(done)
  );

  function automatic void chk(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference model: edges since (re)load, whether a sequence is live, its round.
  int m_cnt  = 0;
  bit m_seq  = 1'b0;
  int m_rnd  = 0;
  bit m_done = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt <= 0; m_seq <= 1'b0; m_rnd <= 0; m_done <= 1'b0;
    end else if (key_reload) begin
      m_cnt <= 0; m_seq <= 1'b0; m_rnd <= 0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt < LOAD_EDGES) m_cnt <= m_cnt + 1;
      if (m_cnt >= LOAD_EDGES) begin
        if (m_seq) begin
          if (rk_ready) begin
            if (m_rnd == NRND) begin
              m_seq <= 1'b0; m_rnd <= 0; m_done <= 1'b1;
            end else begin
              m_rnd <= m_rnd + 1;
            end
          end
        end else if (start) begin
          m_seq <= 1'b1; m_rnd <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_keys_ready", 128'(keys_ready), 128'(m_cnt >= LOAD_EDGES));
      chk("m_rk_valid",   128'(rk_valid),   128'(m_seq));
      chk("m_busy",       128'(busy),       128'(m_seq));
      chk("m_rk_round",   128'(rk_round),   128'(m_seq ? m_rnd : 0));
      chk("m_rk_last",    128'(rk_last),    128'(m_seq && (m_rnd == NRND)));
      chk("m_done",       128'(done),       128'(m_done));
      if (m_seq) chk("m_rk_data", rk_data, key_in[m_rnd]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rk_valid"},   128'(rk_valid),   '0);
    chk({tag, "_rk_data"},    rk_data,          '0);
    chk({tag, "_rk_round"},   128'(rk_round),   '0);
    chk({tag, "_rk_last"},    128'(rk_last),    '0);
    chk({tag, "_keys_ready"}, 128'(keys_ready), '0);
    chk({tag, "_busy"},       128'(busy),       '0);
    chk({tag, "_done"},       128'(done),       '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    int dn;
    int n;
    key_in[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    key_in[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    key_in[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    key_in[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    key_in[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    key_in[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    key_in[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    key_in[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    key_in[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    key_in[9]  = 128'hac7766f319fadc2128d12941575c006e;
    key_in[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    repeat (3) tick();
    check_all_zero("reset");
    chk_en = 1'b1;
    reset_n = 1'b1;

    // Load timing, with a start pulse sampled at edge 50 that must be ignored.
    repeat (49) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_start_ignored", 128'(rk_valid), '0);
    repeat (79) tick();
    chk("kr_edge129", 128'(keys_ready), '0);
    tick();
    chk("kr_edge130", 128'(keys_ready), 128'(1));

    // Full sequence with rk_ready held high.
    start = 1'b1;
    tick();
    start = 1'b0;
    rk_ready = 1'b1;
    for (int i = 0; i <= NRND; i++) begin
      chk("seq_valid", 128'(rk_valid), 128'(1));
      chk("seq_round", 128'(rk_round), 128'(i));
      chk("seq_last",  128'(rk_last),  128'(i == NRND));
      if (i == 0)    chk("seq_key0",  rk_data, K0_LIT);
      if (i == 1)    chk("seq_key1",  rk_data, K1_LIT);
      if (i == NRND) chk("seq_key10", rk_data, K10_LIT);
      tick();
    end
    chk("seq_done",        128'(done),     128'(1));
    chk("seq_valid_after", 128'(rk_valid), '0);
    tick();
    chk("seq_done_pulse",  128'(done),     '0);

    // Backpressure: no acceptance for 5 cycles while round 3 is presented.
    start = 1'b1;
    tick();
    start = 1'b0;
    vc = 0; dn = 0;
    for (int t = 0; t < 40; t++) begin
      rk_ready = !(t >= 3 && t <= 7);
      if (rk_valid) vc++;
      if (done) dn++;
      if (t >= 3 && t <= 8) begin
        chk("bp_round", 128'(rk_round), 128'(3));
        chk("bp_data",  rk_data, K3_LIT);
        chk("bp_valid", 128'(rk_valid), 128'(1));
      end
      tick();
    end
    chk("bp_valid_cycles", 128'(vc), 128'(16));
    chk("bp_done_count",   128'(dn), 128'(1));

    // Start during ISSUE at round 5 must not restart or extend the sequence.
    rk_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    vc = 0; dn = 0;
    for (int t = 0; t < 30; t++) begin
      start = (t == 5);
      if (rk_valid) vc++;
      if (done) dn++;
      tick();
    end
    start = 1'b0;
    chk("issue_start_valid_cycles", 128'(vc), 128'(11));
    chk("issue_start_done_count",   128'(dn), 128'(1));

    // key_reload with start at round 6: abort without done, reload count from 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("rl_round6", 128'(rk_round), 128'(6));
    key_reload = 1'b1;
    start = 1'b1;
    tick();
    key_reload = 1'b0;
    start = 1'b0;
    chk("rl_valid",      128'(rk_valid),   '0);
    chk("rl_busy",       128'(busy),       '0);
    chk("rl_done",       128'(done),       '0);
    chk("rl_keys_ready", 128'(keys_ready), '0);
    n = 0; dn = 0;
    while (!keys_ready && n < 200) begin
      if (done || rk_valid) dn++;
      tick();
      n++;
    end
    chk("rl_ready_edges", 128'(n),  128'(LOAD_EDGES));
    chk("rl_no_activity", 128'(dn), '0);

    // Asynchronous reset between edges in the middle of a sequence.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("ar_pre_valid", 128'(rk_valid), 128'(1));
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    rk_ready = 1'b0;
    repeat (129) tick();
    chk("ar_kr_edge129", 128'(keys_ready), '0);
    tick();
    chk("ar_kr_edge130", 128'(keys_ready), 128'(1));

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
